// File: rtl/uart_mmio_ctrl.sv
// rtl/uart_mmio_ctrl.sv - memory-mapped UART controller with TX/RX byte FIFOs and a TX handshake FSM
module uart_mmio_ctrl #(
    parameter logic [31:0] BASE  = 32'h10010000,
    parameter int          DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        write_enable,
    input  logic [3:0]  write_mask,
    input  logic        read_enable,
    output logic [31:0] read_data,
    output logic        hit,
    output logic [7:0]  uart_data,
    output logic        uart_write_enable,
    input  logic        uart_busy,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_out_valid,
    output logic [31:0] clk_frequency,
    output logic [31:0] baud_rate
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [31:0] ADDR_DATA   = BASE;
    localparam logic [31:0] ADDR_STATUS = BASE + 32'h0000_0005;
    localparam logic [31:0] ADDR_CLKF   = BASE + 32'h0000_0100;
    localparam logic [31:0] ADDR_BAUD   = BASE + 32'h0000_0104;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_START,
        ST_WAIT_DONE
    } tx_state_e;

    logic          sel_data, sel_status, sel_clkf, sel_baud;
    logic [PW-1:0] tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
    logic [CW-1:0] tx_cnt_q, rx_cnt_q;
    logic [7:0]    tx_mem_q [DEPTH];
    logic [7:0]    rx_mem_q [DEPTH];
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic          tx_push_req, tx_push, tx_pop, rx_push, rx_pop;
    logic          status_wr;
    logic          tx_overflow_q, tx_overflow_d;
    logic          rx_overrun_q, rx_overrun_d;
    tx_state_e     state_q, state_d;
    logic [1:0]    timer_q, timer_d;
    logic [7:0]    uart_data_q, uart_data_d;
    logic [31:0]   clkf_q, baud_q;
    logic [7:0]    status_byte;
    logic          tx_idle;
    logic          unused_mask;

    assign unused_mask = &{1'b0, write_mask[3:1]};

    assign sel_data   = (address == ADDR_DATA);
    assign sel_status = (address == ADDR_STATUS);
    assign sel_clkf   = (address == ADDR_CLKF);
    assign sel_baud   = (address == ADDR_BAUD);
    assign hit        = sel_data | sel_status | sel_clkf | sel_baud;

    assign tx_full  = (tx_cnt_q == FULL_CNT);
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == FULL_CNT);
    assign rx_empty = (rx_cnt_q == '0);

    assign tx_push_req = write_enable & sel_data & write_mask[0];
    assign tx_push     = tx_push_req & ~tx_full;
    assign rx_pop      = read_enable & sel_data & ~rx_empty;
    // A pop in the same cycle frees the slot, so a full RX FIFO still accepts.
    assign rx_push     = uart_out_valid & (~rx_full | rx_pop);

    assign status_wr     = write_enable & sel_status;
    assign tx_overflow_d = (tx_push_req & tx_full)
                         | (tx_overflow_q & ~(status_wr & write_data[3]));
    assign rx_overrun_d  = (uart_out_valid & rx_full & ~rx_pop)
                         | (rx_overrun_q & ~(status_wr & write_data[1]));

    assign tx_idle     = tx_empty & (state_q == ST_IDLE) & ~uart_busy;
    assign status_byte = {tx_idle, ~tx_full, 2'b00, tx_overflow_q, 1'b0, rx_overrun_q, ~rx_empty};

    always_comb begin
        read_data = '0;
        if (sel_data) begin
            read_data = rx_empty ? 32'd0 : {24'd0, rx_mem_q[rx_rd_q]};
        end else if (sel_status) begin
            read_data = {24'd0, status_byte};
        end else if (sel_clkf) begin
            read_data = clkf_q;
        end else if (sel_baud) begin
            read_data = baud_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        uart_data_d = uart_data_q;
        tx_pop      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!tx_empty && !uart_busy) begin
                    tx_pop      = 1'b1;
                    uart_data_d = tx_mem_q[tx_rd_q];
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                timer_d = '0;
                state_d = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                // Give up after four cycles if the transmitter never reports busy.
                if (uart_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (timer_q == 2'd3) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + 2'd1;
                end
            end
            ST_WAIT_DONE: begin
                if (!uart_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign uart_write_enable = (state_q == ST_ISSUE);
    assign uart_data         = uart_data_q;
    assign clk_frequency     = clkf_q;
    assign baud_rate         = baud_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            uart_data_q   <= 8'hFF;
            tx_wr_q       <= '0;
            tx_rd_q       <= '0;
            tx_cnt_q      <= '0;
            rx_wr_q       <= '0;
            rx_rd_q       <= '0;
            rx_cnt_q      <= '0;
            tx_overflow_q <= 1'b0;
            rx_overrun_q  <= 1'b0;
            clkf_q        <= 32'h0000FFC0;
            baud_q        <= 32'd11520;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            uart_data_q   <= uart_data_d;
            tx_overflow_q <= tx_overflow_d;
            rx_overrun_q  <= rx_overrun_d;
            if (tx_push) begin
                tx_wr_q <= tx_wr_q + PW'(1);
            end
            if (tx_pop) begin
                tx_rd_q <= tx_rd_q + PW'(1);
            end
            tx_cnt_q <= tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
            if (rx_push) begin
                rx_wr_q <= rx_wr_q + PW'(1);
            end
            if (rx_pop) begin
                rx_rd_q <= rx_rd_q + PW'(1);
            end
            rx_cnt_q <= rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
            if (write_enable && sel_clkf) begin
                clkf_q <= write_data;
            end
            if (write_enable && sel_baud) begin
                baud_q <= write_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem_q[tx_wr_q] <= write_data[7:0];
        end
        if (rx_push) begin
            rx_mem_q[rx_wr_q] <= uart_rx_data;
        end
    end
endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// tb/tb_uart_mmio_ctrl.sv - directed and randomized checks of uart_mmio_ctrl against a queue-based model
module tb_uart_mmio_ctrl;
    localparam logic [31:0] BASE     = 32'h10010000;
    localparam int          DEPTH    = 8;
    localparam logic [31:0] A_DATA   = BASE;
    localparam logic [31:0] A_STATUS = BASE + 32'h5;
    localparam logic [31:0] A_CLKF   = BASE + 32'h100;
    localparam logic [31:0] A_BAUD   = BASE + 32'h104;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        write_enable;
    logic [3:0]  write_mask;
    logic        read_enable;
    logic [31:0] read_data;
    logic        hit;
    logic [7:0]  uart_data;
    logic        uart_write_enable;
    logic        uart_busy;
    logic [7:0]  uart_rx_data;
    logic        uart_out_valid;
    logic [31:0] clk_frequency;
    logic [31:0] baud_rate;

    uart_mmio_ctrl #(.BASE(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .address(address), .write_data(write_data),
        .write_enable(write_enable), .write_mask(write_mask), .read_enable(read_enable),
        .read_data(read_data), .hit(hit), .uart_data(uart_data),
        .uart_write_enable(uart_write_enable), .uart_busy(uart_busy),
        .uart_rx_data(uart_rx_data), .uart_out_valid(uart_out_valid),
        .clk_frequency(clk_frequency), .baud_rate(baud_rate)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];
    bit          m_txovf, m_rxovr;
    logic [31:0] m_clkf, m_baud;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        address      = '0;
        write_data   = '0;
        write_enable = 1'b0;
        write_mask   = '0;
        read_enable  = 1'b0;
    endtask

    task automatic m_reset();
        tx_q.delete();
        rx_q.delete();
        m_txovf = 1'b0;
        m_rxovr = 1'b0;
        m_clkf  = 32'h0000FFC0;
        m_baud  = 32'd11520;
    endtask

    function automatic logic [31:0] m_status(input bit fsm_idle);
        logic tx_idle;
        tx_idle = fsm_idle && (tx_q.size() == 0) && !uart_busy;
        return {24'd0, tx_idle, (tx_q.size() < DEPTH), 2'b00, m_txovf, 1'b0, m_rxovr, (rx_q.size() != 0)};
    endfunction

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        address = a; write_data = d; write_mask = m; write_enable = 1'b1;
        step();
        idle_bus();
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic pop, input logic [31:0] exp);
        address = a; read_enable = pop;
        #1;
        check(tag, read_data, exp);
        step();
        idle_bus();
    endtask

    task automatic rx_in(input logic [7:0] b);
        uart_rx_data = b; uart_out_valid = 1'b1;
        step();
        uart_out_valid = 1'b0;
        if (rx_q.size() < DEPTH) rx_q.push_back(b);
        else m_rxovr = 1'b1;
    endtask

    // Acts as the transmitter: each send pulse is answered with three busy cycles.
    task automatic drain(input int n);
        int got = 0;
        int hold = 0;
        uart_busy = 1'b0;
        for (int c = 0; c < 12 * n + 20; c++) begin
            step();
            if (hold > 0) begin
                hold--;
                if (hold == 0) uart_busy = 1'b0;
            end
            if (uart_write_enable) begin
                got++;
                if (tx_q.size() > 0) check("tx_byte", {24'd0, uart_data}, {24'd0, tx_q.pop_front()});
                uart_busy = 1'b1;
                hold = 3;
            end
        end
        check("tx_count", got, n);
    endtask

    initial begin
        logic [31:0] bad_addr [5];
        logic [31:0] a, wd, exp_rd;
        logic [3:0]  wm;
        logic [7:0]  rb;
        logic        vld, do_rst, exp_hit, pop, set_tx, set_rx, clr_tx, clr_rx;
        int          op, pulses;

        bad_addr[0] = BASE + 32'h1;
        bad_addr[1] = BASE + 32'h4;
        bad_addr[2] = BASE + 32'h101;
        bad_addr[3] = BASE + 32'h108;
        bad_addr[4] = 32'h0;

        idle_bus();
        uart_busy = 1'b0; uart_rx_data = '0; uart_out_valid = 1'b0;
        rst = 1'b1;
        m_reset();
        step(); step();
        rst = 1'b0;
        #1;

        check("rst_status", read_data, 32'h0);
        address = A_STATUS; #1;
        check("rst_status_val", read_data, 32'hC0);
        check("rst_status_hit", {31'd0, hit}, 32'd1);
        address = BASE + 32'h4; #1;
        check("unmapped_hit", {31'd0, hit}, 32'd0);
        check("unmapped_rd", read_data, 32'd0);
        idle_bus();
        check("rst_clkf", clk_frequency, 32'h0000FFC0);
        check("rst_baud", baud_rate, 32'd11520);
        check("rst_we", {31'd0, uart_write_enable}, 32'd0);
        check("rst_udata", {24'd0, uart_data}, 32'hFF);

        // Single byte with a cooperative transmitter.
        wr(A_DATA, 32'h41, 4'h1);
        check("t1_no_pulse_yet", {31'd0, uart_write_enable}, 32'd0);
        step();
        check("t1_pulse", {31'd0, uart_write_enable}, 32'd1);
        check("t1_data", {24'd0, uart_data}, 32'h41);
        uart_busy = 1'b1;
        step();
        check("t1_pulse_one_cycle", {31'd0, uart_write_enable}, 32'd0);
        step();
        address = A_STATUS; #1;
        check("t1_busy_not_idle", {31'd0, read_data[7]}, 32'd0);
        uart_busy = 1'b0;
        step(); #1;
        check("t1_idle_after", read_data, 32'hC0);
        check("t1_data_held", {24'd0, uart_data}, 32'h41);
        idle_bus();

        // Start timeout: busy never rises, four WAIT_START cycles then IDLE.
        wr(A_DATA, 32'h5A, 4'hF);
        step();
        check("t6_pulse", {31'd0, uart_write_enable}, 32'd1);
        address = A_STATUS;
        for (int k = 1; k <= 5; k++) begin
            step();
            check($sformatf("t6_timeout_k%0d", k), {31'd0, read_data[7]}, (k == 5) ? 32'd1 : 32'd0);
        end
        idle_bus();

        // Reset while waiting for the transmitter to finish.
        wr(A_DATA, 32'h33, 4'h1);
        step();
        check("t6b_pulse", {31'd0, uart_write_enable}, 32'd1);
        uart_busy = 1'b1;
        step(); step();
        wr(A_DATA, 32'h44, 4'h1);
        rx_in(8'h77);
        address = A_STATUS; #1;
        check("t6b_pre_rst_status", read_data, 32'h41);
        idle_bus();
        rst = 1'b1;
        step();
        rst = 1'b0; uart_busy = 1'b0;
        m_reset();
        address = A_STATUS; #1;
        check("t6b_post_rst_status", read_data, 32'hC0);
        check("t6b_post_rst_udata", {24'd0, uart_data}, 32'hFF);
        idle_bus();
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (uart_write_enable) pulses++;
        end
        check("t6b_no_pulse_after_rst", pulses, 0);

        // Nine writes while the transmitter is busy: the ninth overflows.
        uart_busy = 1'b1;
        for (int i = 0; i < 9; i++) begin
            wr(A_DATA, 32'h10 + i, 4'hF);
            if (tx_q.size() < DEPTH) tx_q.push_back(8'(8'h10 + i));
            else m_txovf = 1'b1;
        end
        rd("t2_status_full", A_STATUS, 1'b0, 32'h08);
        drain(8);
        rd("t2_status_drained", A_STATUS, 1'b0, 32'hC8);
        wr(A_STATUS, 32'h08, 4'h1);
        m_txovf = 1'b0;
        rd("t2_status_cleared", A_STATUS, 1'b0, 32'hC0);

        // RX basic order and empty read.
        rx_in(8'h55);
        rx_in(8'hAA);
        rd("t3_status_ne", A_STATUS, 1'b0, 32'hC1);
        rd("t3_rd0", A_DATA, 1'b1, 32'h55);
        rd("t3_rd1", A_DATA, 1'b1, 32'hAA);
        rd("t3_rd_empty", A_DATA, 1'b1, 32'h0);
        rd("t3_status_e", A_STATUS, 1'b0, 32'hC0);
        rx_q.delete();

        // RX full: simultaneous push/pop, overrun, set-beats-clear, W1C.
        for (int i = 0; i < DEPTH; i++) rx_in(8'(8'h80 + i));
        rd("t4_status_full", A_STATUS, 1'b0, m_status(1'b1));
        address = A_DATA; read_enable = 1'b1; uart_rx_data = 8'hE0; uart_out_valid = 1'b1;
        #1;
        check("t4_simul_head", read_data, 32'h80);
        step();
        idle_bus(); uart_out_valid = 1'b0;
        void'(rx_q.pop_front());
        rx_q.push_back(8'hE0);
        rd("t4_no_overrun", A_STATUS, 1'b0, 32'hC1);
        rx_in(8'hE1);
        rd("t4_overrun", A_STATUS, 1'b0, 32'hC3);
        address = A_STATUS; write_data = 32'h02; write_mask = 4'hF; write_enable = 1'b1;
        uart_rx_data = 8'hE2; uart_out_valid = 1'b1;
        step();
        idle_bus(); uart_out_valid = 1'b0;
        rd("t4_set_wins", A_STATUS, 1'b0, 32'hC3);
        wr(A_STATUS, 32'h02, 4'h1);
        m_rxovr = 1'b0;
        rd("t4_cleared", A_STATUS, 1'b0, 32'hC1);
        while (rx_q.size() > 0) rd("t4_drain", A_DATA, 1'b1, {24'd0, rx_q.pop_front()});
        rd("t4_drained_empty", A_DATA, 1'b1, 32'h0);

        // Timing configuration registers, mask ignored.
        wr(A_CLKF, 32'h02FAF080, 4'h0);
        check("t5_clkf", clk_frequency, 32'h02FAF080);
        wr(A_BAUD, 32'd115200, 4'h0);
        check("t5_baud", baud_rate, 32'd115200);
        rd("t5_clkf_rd", A_CLKF, 1'b0, 32'h02FAF080);
        rd("t5_baud_rd", A_BAUD, 1'b0, 32'd115200);
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_reset();
        check("t5_rst_clkf", clk_frequency, 32'h0000FFC0);
        check("t5_rst_baud", baud_rate, 32'd11520);

        // Randomized traffic with the transmitter held busy, then drained.
        uart_busy = 1'b1;
        for (int it = 0; it < 300; it++) begin
            op     = $urandom_range(0, 7);
            wd     = $urandom;
            wm     = 4'($urandom);
            vld    = 1'($urandom);
            rb     = 8'($urandom);
            do_rst = ($urandom_range(0, 59) == 0);
            idle_bus();
            case (op)
                0: begin a = A_DATA; write_enable = 1'b1; end
                1: begin a = A_DATA; read_enable = 1'b1; end
                2: a = A_DATA;
                3: a = A_STATUS;
                4: begin a = A_STATUS; write_enable = 1'b1; end
                5: begin a = A_BAUD; write_enable = 1'b1; end
                6: a = A_CLKF;
                default: begin a = bad_addr[$urandom_range(0, 4)]; write_enable = 1'($urandom); end
            endcase
            address = a; write_data = wd; write_mask = wm;
            uart_rx_data = rb; uart_out_valid = vld; rst = do_rst;
            if (a == A_DATA) exp_rd = (rx_q.size() != 0) ? {24'd0, rx_q[0]} : 32'd0;
            else if (a == A_STATUS) exp_rd = m_status(1'b1);
            else if (a == A_BAUD) exp_rd = m_baud;
            else if (a == A_CLKF) exp_rd = m_clkf;
            else exp_rd = 32'd0;
            exp_hit = (a == A_DATA) || (a == A_STATUS) || (a == A_BAUD) || (a == A_CLKF);
            #1;
            check($sformatf("rnd%0d_rd op%0d", it, op), read_data, exp_rd);
            check($sformatf("rnd%0d_hit", it), {31'd0, hit}, {31'd0, exp_hit});
            @(posedge clk);
            if (do_rst) begin
                m_reset();
            end else begin
                pop    = (op == 1) && (rx_q.size() != 0);
                clr_tx = (op == 4) && wd[3];
                clr_rx = (op == 4) && wd[1];
                set_tx = 1'b0;
                set_rx = 1'b0;
                if (pop) void'(rx_q.pop_front());
                if (vld) begin
                    if (rx_q.size() < DEPTH) rx_q.push_back(rb);
                    else set_rx = 1'b1;
                end
                if (op == 0 && wm[0]) begin
                    if (tx_q.size() < DEPTH) tx_q.push_back(wd[7:0]);
                    else set_tx = 1'b1;
                end
                m_txovf = set_tx || (m_txovf && !clr_tx);
                m_rxovr = set_rx || (m_rxovr && !clr_rx);
                if (op == 5) m_baud = wd;
            end
            #1;
            idle_bus(); uart_out_valid = 1'b0; rst = 1'b0;
            check($sformatf("rnd%0d_baud", it), baud_rate, m_baud);
            check($sformatf("rnd%0d_clkf", it), clk_frequency, m_clkf);
        end
        drain(tx_q.size());
        rd("rnd_final_status", A_STATUS, 1'b0, m_status(1'b1));
        while (rx_q.size() > 0) rd("rnd_rx_drain", A_DATA, 1'b1, {24'd0, rx_q.pop_front()});
        rd("rnd_rx_empty", A_DATA, 1'b1, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
